// File: rtl/writeback_stage.sv
// Register-file write-back stage: arbitrates ALU results and in-order load
// returns onto one write port, and keeps a load-use scoreboard for decode.

module writeback_stage_pend #(
  parameter int LQ_DEPTH = 4,
  parameter int RW       = 5,
  parameter int REG_IDX  = 0
) (
  input  logic [LQ_DEPTH-1:0][RW-1:0] i_dest,
  input  logic [LQ_DEPTH-1:0]         i_live,
  input  logic                        i_wb_ld,
  input  logic [RW-1:0]               i_wb_rd,
  output logic                        o_pend
);
  always_comb begin
    // A load write on the port still counts until the register file has it.
    o_pend = i_wb_ld && (i_wb_rd == RW'(REG_IDX));
    for (int e = 0; e < LQ_DEPTH; e++)
      if (i_live[e] && (i_dest[e] == RW'(REG_IDX))) o_pend = 1'b1;
  end
endmodule

module writeback_stage #(
  parameter  int LQ_DEPTH = 4,
  parameter  int NUM_REGS = 32,
  parameter  int REG_W    = 32,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [RW-1:0]       alu_rd,
  input  logic [REG_W-1:0]    alu_val,
  output logic                alu_ready,
  input  logic                ld_issue,
  input  logic [RW-1:0]       ld_issue_rd,
  output logic                ld_issue_ready,
  input  logic                ld_ret_valid,
  input  logic [REG_W-1:0]    ld_ret_val,
  output logic                ld_ret_ready,
  input  logic [RW-1:0]       chk_rs,
  input  logic [RW-1:0]       chk_rt,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending,
  output logic [RW-1:0]       rd,
  output logic [REG_W-1:0]    reg_in,
  output logic                write_en
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RW-1:0]    dest;
    logic [REG_W-1:0] data;
  } lq_ent_t;

  lq_ent_t [LQ_DEPTH-1:0]       r_ent;
  logic [LQ_DEPTH-1:0]          r_has;
  logic [PW-1:0]                r_head, r_fill, r_tail;
  logic [CW-1:0]                r_count, r_wait;
  logic                         r_wb_is_load;

  logic                         w_full, w_head_rdy, w_load_wins;
  logic                         w_iss, w_ret;
  logic [LQ_DEPTH-1:0]          w_live;
  logic [LQ_DEPTH-1:0][RW-1:0]  w_dest;
  logic [PW-1:0]                w_off;

  assign w_full         = (r_count == CW'(LQ_DEPTH));
  // has_data is cleared on pop, so an empty queue never shows a ready head.
  assign w_head_rdy     = r_has[r_head];
  assign alu_ready      = !(w_head_rdy && w_full);
  assign w_load_wins    = w_head_rdy && (w_full || !alu_valid);
  assign ld_issue_ready = !w_full;
  // r_wait counts entries still awaiting data; a return only pairs with those.
  assign ld_ret_ready   = (r_wait != '0);
  assign w_iss          = ld_issue && ld_issue_ready;
  assign w_ret          = ld_ret_valid && ld_ret_ready;

  always_comb begin
    w_off = '0;
    for (int e = 0; e < LQ_DEPTH; e++) begin
      w_off     = PW'(e) - r_head;
      w_live[e] = ({1'b0, w_off} < r_count);
      w_dest[e] = r_ent[e].dest;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    writeback_stage_pend #(.LQ_DEPTH(LQ_DEPTH), .RW(RW), .REG_IDX(g)) u_pend (
      .i_dest  (w_dest),
      .i_live  (w_live),
      .i_wb_ld (write_en && r_wb_is_load),
      .i_wb_rd (rd),
      .o_pend  (pending[g])
    );
  end

  assign stall = pending[chk_rs] | pending[chk_rt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ent        <= '0;
      r_has        <= '0;
      r_head       <= '0;
      r_fill       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_wait       <= '0;
      r_wb_is_load <= 1'b0;
      rd           <= '0;
      reg_in       <= '0;
      write_en     <= 1'b0;
    end else begin
      // tail, fill and head never alias when their operations fire together.
      if (w_iss) begin
        r_ent[r_tail].dest <= ld_issue_rd;
        r_has[r_tail]      <= 1'b0;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_ret) begin
        r_ent[r_fill].data <= ld_ret_val;
        r_has[r_fill]      <= 1'b1;
        r_fill             <= r_fill + PW'(1);
      end
      if (w_load_wins) begin
        r_has[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
        rd            <= r_ent[r_head].dest;
        reg_in        <= r_ent[r_head].data;
        write_en      <= 1'b1;
        r_wb_is_load  <= 1'b1;
      end else if (alu_valid && alu_ready) begin
        rd           <= alu_rd;
        reg_in       <= alu_val;
        write_en     <= 1'b1;
        r_wb_is_load <= 1'b0;
      end else begin
        write_en     <= 1'b0;
        r_wb_is_load <= 1'b0;
      end
      r_count <= r_count + CW'(w_iss) - CW'(w_load_wins);
      r_wait  <= r_wait + CW'(w_iss) - CW'(w_ret);
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU path, loads, contention, full queue,
// same-destination loads and mid-operation reset.

module tb_writeback_stage;
  localparam int D  = 4;
  localparam int NR = 32;
  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [RW-1:0] alu_rd;
  logic [W-1:0]  alu_val;
  logic          alu_ready;
  logic          ld_issue;
  logic [RW-1:0] ld_issue_rd;
  logic          ld_issue_ready;
  logic          ld_ret_valid;
  logic [W-1:0]  ld_ret_val;
  logic          ld_ret_ready;
  logic [RW-1:0] chk_rs, chk_rt;
  logic          stall;
  logic [NR-1:0] pending;
  logic [RW-1:0] rd;
  logic [W-1:0]  reg_in;
  logic          write_en;

  int checks = 0;
  int errors = 0;

  writeback_stage #(.LQ_DEPTH(D), .NUM_REGS(NR), .REG_W(W)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_ret_valid(ld_ret_valid), .ld_ret_val(ld_ret_val), .ld_ret_ready(ld_ret_ready),
    .chk_rs(chk_rs), .chk_rt(chk_rt), .stall(stall), .pending(pending),
    .rd(rd), .reg_in(reg_in), .write_en(write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic [RW-1:0] erd, input logic [W-1:0] ev);
    chk({tag, "_we"}, write_en, 1'b1);
    chk({tag, "_rd"}, rd, erd);
    chk({tag, "_val"}, reg_in, ev);
  endtask

  initial begin
    rst = 1'b0; alu_valid = 0; alu_rd = 0; alu_val = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_ret_valid = 0; ld_ret_val = 0;
    chk_rs = 0; chk_rt = 0;
    #1;
    chk("rst_we", write_en, 0);
    chk("rst_rd", rd, 0);
    chk("rst_val", reg_in, 0);
    chk("rst_pend", pending, 0);
    chk("rst_stall", stall, 0);
    chk("rst_iss_rdy", ld_issue_ready, 1);
    chk("rst_ret_rdy", ld_ret_ready, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // ALU only
    alu_valid = 1; alu_rd = 1; alu_val = 32'h2A;
    chk("alu_rdy", alu_ready, 1);
    cyc();
    alu_valid = 0;
    wr("alu", 1, 32'h2A);
    chk("alu_pend", pending, 0);
    cyc();
    chk("alu_we_off", write_en, 0);
    chk("alu_rd_hold", rd, 1);
    chk("alu_val_hold", reg_in, 32'h2A);

    // Single load to r2
    ld_issue = 1; ld_issue_rd = 2; chk_rs = 2;
    chk("ld_pre_stall", stall, 0);
    cyc();
    ld_issue = 0;
    chk("ld_pend_a", pending, 32'h4);
    chk("ld_stall_a", stall, 1);
    chk("ld_ret_rdy", ld_ret_ready, 1);
    cyc();
    chk("ld_pend_b", pending, 32'h4);
    ld_ret_valid = 1; ld_ret_val = 32'h55;
    cyc();
    ld_ret_valid = 0;
    chk("ld_we_wait", write_en, 0);
    chk("ld_pend_c", pending, 32'h4);
    chk("ld_ret_rdy_off", ld_ret_ready, 0);
    cyc();
    wr("ld", 2, 32'h55);
    chk("ld_pend_d", pending, 32'h4);
    chk("ld_stall_d", stall, 1);
    cyc();
    chk("ld_we_off", write_en, 0);
    chk("ld_pend_e", pending, 0);
    chk("ld_stall_e", stall, 0);
    chk_rs = 0;

    // Contention: ALU held, load to r3 deferred
    alu_valid = 1; alu_rd = 1; alu_val = 32'h10; ld_issue = 1; ld_issue_rd = 3;
    cyc();
    ld_issue = 0; ld_ret_valid = 1; ld_ret_val = 32'h33;
    wr("ct1", 1, 32'h10);
    cyc();
    ld_ret_valid = 0; alu_val = 32'h11;
    wr("ct2", 1, 32'h10);
    chk("ct_alu_rdy", alu_ready, 1);
    chk("ct_iss_rdy", ld_issue_ready, 1);
    cyc();
    wr("ct3", 1, 32'h11);
    chk("ct_pend", pending, 32'h8);
    alu_valid = 0;
    cyc();
    wr("ct4", 3, 32'h33);
    chk("ct_pend_wb", pending, 32'h8);
    cyc();
    chk("ct_we_off", write_en, 0);
    chk("ct_pend_off", pending, 0);

    // Full queue with ALU streaming
    alu_valid = 1; alu_rd = 9; alu_val = 32'hA0; ld_issue = 1; ld_issue_rd = 1;
    cyc();
    ld_issue_rd = 2; ld_ret_valid = 1; ld_ret_val = 32'hD1;
    cyc();
    ld_issue_rd = 3; ld_ret_val = 32'hD2;
    cyc();
    ld_issue_rd = 4; ld_ret_val = 32'hD3;
    chk("fq_iss_rdy3", ld_issue_ready, 1);
    chk("fq_alu_rdy3", alu_ready, 1);
    cyc();
    ld_issue = 0; ld_ret_val = 32'hD4;
    chk("fq_iss_rdy4", ld_issue_ready, 0);
    chk("fq_alu_rdy4", alu_ready, 0);
    chk("fq_ret_rdy4", ld_ret_ready, 1);
    chk("fq_pend4", pending, 32'h1E);
    wr("fq_alu", 9, 32'hA0);
    cyc();
    ld_ret_valid = 0;
    wr("fq_r1", 1, 32'hD1);
    chk("fq_alu_back", alu_ready, 1);
    chk("fq_iss_back", ld_issue_ready, 1);
    chk("fq_pend5", pending, 32'h1E);
    cyc();
    wr("fq_alu2", 9, 32'hA0);
    chk("fq_pend6", pending, 32'h1C);
    alu_valid = 0;
    cyc();
    wr("fq_r2", 2, 32'hD2);
    cyc();
    wr("fq_r3", 3, 32'hD3);
    cyc();
    wr("fq_r4", 4, 32'hD4);
    chk("fq_pend9", pending, 32'h10);
    cyc();
    chk("fq_we_off", write_en, 0);
    chk("fq_pend_off", pending, 0);
    chk("fq_ret_rdy_off", ld_ret_ready, 0);

    // Same-destination loads to r5
    chk_rt = 5;
    ld_issue = 1; ld_issue_rd = 5;
    cyc();
    chk("sd_pend1", pending, 32'h20);
    chk("sd_stall1", stall, 1);
    ld_ret_valid = 1; ld_ret_val = 32'h11;
    cyc();
    ld_issue = 0; ld_ret_val = 32'h22;
    chk("sd_pend2", pending, 32'h20);
    cyc();
    ld_ret_valid = 0;
    wr("sd_w1", 5, 32'h11);
    chk("sd_pend3", pending, 32'h20);
    cyc();
    wr("sd_w2", 5, 32'h22);
    chk("sd_stall4", stall, 1);
    cyc();
    chk("sd_we_off", write_en, 0);
    chk("sd_pend_off", pending, 0);
    chk("sd_stall_off", stall, 0);
    chk_rt = 0;

    // Return with nothing outstanding is dropped
    ld_ret_valid = 1; ld_ret_val = 32'h99;
    cyc();
    ld_ret_valid = 0;
    chk("pe_we", write_en, 0);
    chk("pe_ret_rdy", ld_ret_ready, 0);
    cyc();
    chk("pe_we2", write_en, 0);

    // Reset mid-operation
    chk_rs = 2;
    ld_issue = 1; ld_issue_rd = 1;
    cyc();
    ld_issue_rd = 2; ld_ret_valid = 1; ld_ret_val = 32'h77;
    cyc();
    ld_issue = 0; ld_ret_valid = 0;
    cyc();
    wr("rs_pre", 1, 32'h77);
    chk("rs_pre_pend", pending, 32'h6);
    rst = 1'b0;
    #1;
    chk("rs_we", write_en, 0);
    chk("rs_rd", rd, 0);
    chk("rs_val", reg_in, 0);
    chk("rs_pend", pending, 0);
    chk("rs_stall", stall, 0);
    chk("rs_ret_rdy", ld_ret_ready, 0);
    chk("rs_iss_rdy", ld_issue_ready, 1);
    chk("rs_alu_rdy", alu_ready, 1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rs_post_ret_rdy", ld_ret_ready, 0);
    chk("rs_post_we", write_en, 0);
    chk_rs = 6;
    ld_issue = 1; ld_issue_rd = 6;
    cyc();
    ld_issue = 0; ld_ret_valid = 1; ld_ret_val = 32'h66;
    chk("rs_pend6", pending, 32'h40);
    cyc();
    ld_ret_valid = 0;
    chk("rs_stall6", stall, 1);
    cyc();
    wr("rs_w6", 6, 32'h66);
    cyc();
    chk("rs_we_off", write_en, 0);
    chk("rs_pend_off", pending, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
